step_addr_updater: RTL and testbench

//  Consumer of the blitter step register: applies the latched step value to a

---
 rtl/blit_pkg.sv | 7 +
 rtl/step_adder.sv | 23 ++
 rtl/step_addr_updater.sv | 56 +++++
 tb/tb_step_addr_updater.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// blit_pkg: shared types and default widths for the blitter address step path
package blit_pkg;
  localparam int ADDR_W = 21;
  localparam int STEP_W = 8;
  localparam int LINE_INC = 256;
  typedef enum logic [1:0] {IDLE, RUN, FIN} step_state_t;
endpackage

// File: rtl/step_adder.sv
// step_adder: combinational next address/fraction for one blitter step
module step_adder #(
  parameter int ADDR_W = blit_pkg::ADDR_W,
  parameter int STEP_W = blit_pkg::STEP_W,
  parameter int LINE_INC = blit_pkg::LINE_INC
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [STEP_W-1:0] frac,
  input  logic [STEP_W-1:0] step,
  input  logic              stepm1,
  input  logic              yfrac,
  output logic [ADDR_W-1:0] next_addr,
  output logic [STEP_W-1:0] next_frac
);
  logic [STEP_W:0] fsum;
  logic [ADDR_W-1:0] delta;
  always_comb begin
    fsum = {1'b0, frac} + {1'b0, step};
    delta = yfrac ? (fsum[STEP_W] ? ADDR_W'(LINE_INC) : '0) : ADDR_W'(step);
    next_addr = stepm1 ? addr - delta : addr + delta;
    next_frac = yfrac ? fsum[STEP_W-1:0] : frac;
  end
endmodule

// File: rtl/step_addr_updater.sv
// step_addr_updater: applies the latched step to the blitter address once per granted cycle
module step_addr_updater #(
  parameter int ADDR_W = blit_pkg::ADDR_W,
  parameter int STEP_W = blit_pkg::STEP_W,
  parameter int LINE_INC = blit_pkg::LINE_INC
) (
  input  logic              MasterClock,
  input  logic              RESET,
  input  logic              LDADR,
  input  logic [ADDR_W-1:0] ADRIN,
  input  logic [STEP_W-1:0] STEP,
  input  logic              STEPM1,
  input  logic              YFRAC,
  input  logic              START,
  input  logic [7:0]        CNTIN,
  input  logic              ADV,
  output logic [ADDR_W-1:0] ADDR,
  output logic              BUSY,
  output logic              DONE
);
  import blit_pkg::*;
  step_state_t state, state_nxt;
  logic [8:0] count;
  logic [STEP_W-1:0] frac, next_frac;
  logic [ADDR_W-1:0] next_addr;
  logic step, launch;
  always_comb begin
    step = state == RUN && ADV;
    launch = state == IDLE && START;
    state_nxt = state == IDLE ? (START ? RUN : IDLE)
              : state == RUN ? (step && count == 9'd1 ? FIN : RUN)
              : IDLE;
  end
  step_adder #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .LINE_INC(LINE_INC)) u_adder (
    .addr(ADDR), .frac(frac), .step(STEP), .stepm1(STEPM1), .yfrac(YFRAC),
    .next_addr(next_addr), .next_frac(next_frac)
  );
  // A load always wins the address; the step still consumes count and fraction
  always_ff @(posedge MasterClock or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ADDR <= '0;
      frac <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      BUSY <= state_nxt == RUN;
      DONE <= state_nxt == FIN;
      ADDR <= LDADR ? ADRIN : step ? next_addr : ADDR;
      frac <= launch ? '0 : step ? next_frac : frac;
      count <= launch ? {~|CNTIN, CNTIN} : step ? count - 9'd1 : count;
    end
  end
endmodule

// File: tb/tb_step_addr_updater.sv
// tb_step_addr_updater: directed and random stimulus against a behavioural model
module tb_step_addr_updater;
  localparam int AMOD = 1 << 21;
  logic clk, rst, ldadr, stepm1, yfrac, start, adv;
  logic [20:0] adrin, addr;
  logic [7:0] stp, cntin;
  logic busy, done;
  int checks, fails;
  int m_addr, m_frac, m_rem;
  bit m_run, m_done;

  step_addr_updater dut (
    .MasterClock(clk), .RESET(rst), .LDADR(ldadr), .ADRIN(adrin), .STEP(stp),
    .STEPM1(stepm1), .YFRAC(yfrac), .START(start), .CNTIN(cntin), .ADV(adv),
    .ADDR(addr), .BUSY(busy), .DONE(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_frac = 0; m_rem = 0; m_run = 0; m_done = 0;
  endtask

  task automatic tick();
    bit idle, fin;
    int delta, f;
    @(posedge clk);
    idle = !m_run && !m_done;
    fin = 0;
    if (m_run && adv) begin
      if (yfrac) begin
        f = m_frac + int'(stp);
        m_frac = f % 256;
        delta = (f >= 256) ? 256 : 0;
      end else delta = int'(stp);
      m_addr = stepm1 ? (m_addr - delta + AMOD) % AMOD : (m_addr + delta) % AMOD;
      fin = (m_rem == 1);
      m_rem--;
    end
    if (ldadr) m_addr = int'(adrin);
    if (idle && start) begin
      m_run = 1;
      m_rem = (cntin == 0) ? 256 : int'(cntin);
      m_frac = 0;
    end
    if (fin) m_run = 0;
    m_done = fin;
    #1;
    check("addr", 32'(addr), 32'(m_addr));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    ldadr = 0;
    start = 0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (m_run && n < budget) begin
      tick();
      n++;
    end
    tick();
    check(tag, 32'(m_run || n >= budget), 32'd0);
  endtask

  initial begin
    int steps, dones;
    checks = 0; fails = 0;
    model_reset();
    {ldadr, stepm1, yfrac, start, adv} = '0;
    adrin = '0; stp = '0; cntin = '0;
    rst = 1;
    #1;
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    #8 rst = 0;

    // 1: +4 steps from 0x1000
    ldadr = 1; adrin = 21'h01000; stp = 8'd4;
    tick();
    start = 1; cntin = 8'd3; adv = 1;
    tick();
    tick(); check("t1_s1", 32'(addr), 32'h1004);
    tick(); check("t1_s2", 32'(addr), 32'h1008);
    tick(); check("t1_s3", 32'(addr), 32'h100C); check("t1_done", 32'(done), 32'd1);
    tick(); check("t1_idle", 32'(busy | done), 32'd0);

    // 2: subtract wraps below zero
    ldadr = 1; adrin = 21'h2; stp = 8'd5; stepm1 = 1; start = 1; cntin = 8'd1;
    tick();
    tick(); check("t2_wrap", 32'(addr), 32'h1FFFFD);
    tick();

    // 3: fractional Y stepping
    ldadr = 1; adrin = '0; stp = 8'h80; stepm1 = 0; yfrac = 1; start = 1; cntin = 8'd4;
    tick();
    tick(); check("t3_s1", 32'(addr), 32'h0);
    tick(); check("t3_s2", 32'(addr), 32'h100);
    tick(); check("t3_s3", 32'(addr), 32'h100);
    tick(); check("t3_s4", 32'(addr), 32'h200);
    tick();

    // 4: count 0 means 256, ADV every other cycle, stray STARTs ignored
    yfrac = 0; stp = 8'd1; start = 1; cntin = 8'd0; adv = 0;
    tick();
    steps = 0; dones = 0;
    for (int i = 0; i < 700 && !done; i++) begin
      adv = i[0];
      start = (i % 37 == 5);
      cntin = 8'd2;
      if (busy && adv) steps++;
      tick();
      if (done) dones++;
    end
    check("t4_steps", 32'(steps), 32'd256);
    check("t4_done", 32'(dones), 32'd1);
    adv = 0;
    tick();

    // 5: load coinciding with a step wins the address, count still moves
    stp = 8'd1; start = 1; cntin = 8'd4; adv = 1;
    tick();
    tick();
    ldadr = 1; adrin = 21'h00500;
    tick(); check("t5_load", 32'(addr), 32'h500);
    tick(); check("t5_after", 32'(addr), 32'h501);
    tick(); check("t5_done", 32'(done), 32'd1);
    tick();

    // 6: asynchronous reset mid-run
    start = 1; cntin = 8'd20;
    tick();
    for (int i = 0; i < 10; i++) tick();
    #1 rst = 1;
    #1;
    check("t6_addr", 32'(addr), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk) rst = 0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    check("t6_nodone", 32'(dones), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      adv = ($urandom_range(0, 3) != 0);
      ldadr = ($urandom_range(0, 15) == 0);
      adrin = 21'($urandom);
      stp = 8'($urandom);
      stepm1 = 1'($urandom);
      yfrac = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      cntin = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      tick();
    end
    adv = 1;
    run_to_done("rand_drain", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
